// File: rtl/operand_fetch.sv
// operand_fetch: reads two register operands per instruction and holds the bundle for execute.
// Define FETCH_BYPASS_EN to forward a same-cycle register-file write into the captured operand.
module operand_fetch #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_opcode,
  input  logic [ADDR_W-1:0] in_src_a,
  input  logic [ADDR_W-1:0] in_src_b,
  input  logic [ADDR_W-1:0] in_dst,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  input  logic              rf_we,
  input  logic [ADDR_W-1:0] rf_write_addr,
  input  logic [DATA_W-1:0] rf_write_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [1:0]        out_opcode,
  output logic [ADDR_W-1:0] out_dst
);
  typedef enum logic [1:0] {IDLE, READ_A, READ_B, HOLD} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
  logic [1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, operand;
  logic accept;
`ifdef FETCH_BYPASS_EN
  assign operand = (rf_we && rf_write_addr == rf_read_addr) ? rf_write_data : rf_read_data;
`else
  logic unused_snoop;
  assign unused_snoop = ^{rf_we, rf_write_addr, rf_write_data};
  assign operand = rf_read_data;
`endif
  always_comb begin
    in_ready = rst && (state_q == IDLE || (state_q == HOLD && out_ready));
    accept = in_valid && in_ready;
    rf_read_addr = state_q == READ_A ? src_a_q : state_q == READ_B ? src_b_q : '0;
    state_d = accept ? READ_A :
              state_q == READ_A ? READ_B :
              state_q == READ_B ? HOLD :
              (state_q == HOLD && out_ready) ? IDLE : state_q;
    src_a_d = accept ? in_src_a : src_a_q;
    src_b_d = accept ? in_src_b : src_b_q;
    dst_d = accept ? in_dst : dst_q;
    opcode_d = accept ? in_opcode : opcode_q;
    a_d = state_q == READ_A ? operand : a_q;
    b_d = state_q == READ_B ? operand : b_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q <= '0;
      opcode_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state_q <= state_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      dst_q <= dst_d;
      opcode_q <= opcode_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end
  assign out_valid = state_q == HOLD;
  assign out_a = a_q;
  assign out_b = b_q;
  assign out_opcode = opcode_q;
  assign out_dst = dst_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: randomized and directed bench comparing operand_fetch against a transaction-level model.
module tb_operand_fetch;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 0, rf_we = 0;
  logic [1:0] in_opcode = 0;
  logic [2:0] in_src_a = 0, in_src_b = 0, in_dst = 0, rf_write_addr = 0;
  logic [7:0] rf_write_data = 0;
  logic in_ready, out_valid;
  logic [2:0] rf_read_addr, out_dst;
  logic [7:0] rf_read_data, out_a, out_b;
  logic [1:0] out_opcode;
  int checks = 0, failures = 0;

  operand_fetch #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_src_a(in_src_a), .in_src_b(in_src_b), .in_dst(in_dst),
    .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .rf_we(rf_we), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_opcode(out_opcode), .out_dst(out_dst));

  always #5 clk = ~clk;

  logic [7:0] regs [8];
  assign rf_read_data = regs[rf_read_addr];
  always @(posedge clk) if (rf_we) regs[rf_write_addr] <= rf_write_data;

  // Model: one pending instruction with the number of edges since it was accepted.
  logic m_have = 0;
  int m_age = 0, acc_cnt = 0, cons_cnt = 0;
  logic [2:0] m_sa = 0, m_sb = 0, m_dst = 0;
  logic [1:0] m_op = 0;
  logic [7:0] m_a = 0, m_b = 0;
  wire m_present = m_have && m_age == 2;
  wire m_in_ready = rst && (!m_have || (m_present && out_ready));
  wire [2:0] m_raddr = (m_have && m_age == 0) ? m_sa : (m_have && m_age == 1) ? m_sb : 3'd0;

  function automatic logic [7:0] fetch(input logic [2:0] a);
    return (BYP && rf_we && rf_write_addr == a) ? rf_write_data : regs[a];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_have <= 0; m_age <= 0; m_a <= 0; m_b <= 0; m_op <= 0; m_dst <= 0; m_sa <= 0; m_sb <= 0;
    end else begin
      if (m_have && m_age == 0) begin m_a <= fetch(m_sa); m_age <= 1; end
      else if (m_have && m_age == 1) begin m_b <= fetch(m_sb); m_age <= 2; end
      if (m_present && out_ready) begin m_have <= 0; cons_cnt <= cons_cnt + 1; end
      if (in_valid && m_in_ready) begin
        m_have <= 1; m_age <= 0; m_sa <= in_src_a; m_sb <= in_src_b;
        m_op <= in_opcode; m_dst <= in_dst; acc_cnt <= acc_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m_present));
    chk("in_ready", 32'(in_ready), 32'(m_in_ready));
    chk("rf_read_addr", 32'(rf_read_addr), 32'(m_raddr));
    chk("out_a", 32'(out_a), 32'(m_a));
    chk("out_b", 32'(out_b), 32'(m_b));
    chk("out_opcode", 32'(out_opcode), 32'(m_op));
    chk("out_dst", 32'(out_dst), 32'(m_dst));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    rf_we = 1; rf_write_addr = a; rf_write_data = d;
    step();
    rf_we = 0;
  endtask

  task automatic offer(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b, input logic [2:0] d);
    in_valid = 1; in_opcode = op; in_src_a = a; in_src_b = b; in_dst = d;
  endtask

  initial begin
    int a0, c0;
    step(); step();
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    rst = 1;
    for (int i = 0; i < 8; i++) wr(3'(i), 8'(i * 17));
    wr(3'd2, 8'h3C); wr(3'd5, 8'hA5);
    chk("idle_in_ready", 32'(in_ready), 1);
    offer(2'b01, 3'd2, 3'd5, 3'd7);
    step();
    in_valid = 0;
    step();
    chk("latency_not_yet", 32'(out_valid), 0);
    step();
    chk("basic_valid", 32'(out_valid), 1);
    chk("basic_a", 32'(out_a), 32'h3C);
    chk("basic_b", 32'(out_b), 32'hA5);
    chk("basic_op", 32'(out_opcode), 1);
    chk("basic_dst", 32'(out_dst), 7);
    for (int i = 0; i < 4; i++) step();
    chk("hold_valid", 32'(out_valid), 1);
    chk("hold_in_ready", 32'(in_ready), 0);
    chk("hold_a", 32'(out_a), 32'h3C);
    chk("hold_b", 32'(out_b), 32'hA5);
    out_ready = 1;
    step();
    chk("consumed_valid", 32'(out_valid), 0);
    chk("consumed_in_ready", 32'(in_ready), 1);
    wr(3'd4, 8'hFF);
    offer(2'b10, 3'd4, 3'd4, 3'd1);
    step(); in_valid = 0; step(); step();
    chk("same_src_a", 32'(out_a), 32'hFF);
    chk("same_src_b", 32'(out_b), 32'hFF);
    step();
    wr(3'd3, 8'h11);
    offer(2'b11, 3'd3, 3'd0, 3'd2);
    step(); in_valid = 0;
    rf_we = 1; rf_write_addr = 3'd3; rf_write_data = 8'h77;
    step(); rf_we = 0;
    step();
    chk("bypass_a", 32'(out_a), BYP ? 32'h77 : 32'h11);
    step();
    offer(2'b01, 3'd1, 3'd6, 3'd5);
    step(); in_valid = 0; step();
    rst = 0; #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_a", 32'(out_a), 0);
    chk("rst_out_b", 32'(out_b), 0);
    chk("rst_opcode", 32'(out_opcode), 0);
    chk("rst_dst", 32'(out_dst), 0);
    chk("rst_raddr", 32'(rf_read_addr), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    step(); step();
    rst = 1; #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_valid", 32'(out_valid), 0);
    step();
    a0 = acc_cnt; c0 = cons_cnt;
    out_ready = 1;
    for (int i = 0; i < 30; i++) begin
      offer(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      step();
    end
    in_valid = 0;
    for (int i = 0; i < 4; i++) step();
    chk("burst_accepts", 32'(acc_cnt - a0), 10);
    chk("burst_consumes", 32'(cons_cnt - c0), 10);
    for (int i = 0; i < 500; i++) begin
      in_valid = ($urandom % 3) != 0;
      in_opcode = 2'($urandom); in_src_a = 3'($urandom); in_src_b = 3'($urandom); in_dst = 3'($urandom);
      out_ready = ($urandom % 4) != 0;
      rf_we = $urandom % 2; rf_write_addr = 3'($urandom); rf_write_data = 8'($urandom);
      rst = ($urandom % 80) != 0;
      step();
    end
    rst = 1; in_valid = 0; rf_we = 0; out_ready = 1;
    step(); step(); step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
